test_wr_ctrl: RTL and testbench
===============================

TEST_WR_CTRL -- requirements
Module: test_wr_ctrl

Interface
REQ-001 SHALL have parameter CTRL_ADDR_WIDTH, default 28, AXI byte-address width.
REQ-002 SHALL have parameter MEM_DQ_WIDTH, default 16, DDR DQ width; data bus width DW = MEM_DQ_WIDTH*8; legal values are multiples of 4 up to 64.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 write_en  input  1  level request from main control to issue one write burst.
REQ-006 random_rw_addr  input  CTRL_ADDR_WIDTH  burst start address.
REQ-007 random_axi_id  input  4  burst AXI ID.
REQ-008 random_axi_len  input  4  burst length minus 1; beats = len+1 (1..16).
REQ-009 write_done_p  output  1  one-cycle pulse when the last data beat is accepted.
REQ-010 axi_awaddr / axi_awid / axi_awlen  output  CTRL_ADDR_WIDTH / 4 / 4  write address channel.
REQ-011 axi_awvalid  output  1;  axi_awready  input  1.
REQ-012 axi_wdata  output  DW;  axi_wstrb  output  DW/8;  axi_wlast  output  1;  axi_wvalid  output  1;  axi_wready  input  1.
REQ-013 wr_busy  output  1  high in any state other than IDLE.
REQ-014 wr_burst_cnt  output  32  count of completed bursts.

Function
REQ-015 States: IDLE, ADDR, DATA, DONE, WAIT_LOW.
REQ-016 IDLE: when write_en=1, latch addr/id/len into registers, clear beat counter, go to ADDR next cycle.
REQ-017 Inputs random_* SHALL be sampled only on the IDLE->ADDR transition; later changes are ignored for the burst in progress.
REQ-018 ADDR: axi_awvalid=1 with latched addr/id/len held stable; on awvalid&awready go to DATA; awvalid deasserts in the same edge.
REQ-019 DATA: axi_wvalid=1; beat counter increments on wvalid&wready; axi_wlast=1 exactly when beat==latched len.
REQ-020 wdata/wlast SHALL be stable while wvalid=1 and wready=0.
REQ-021 On the handshake with wlast=1, go to DONE.
REQ-022 DONE: write_done_p=1 for exactly one cycle; wr_burst_cnt increments by 1 (wraps 0xFFFFFFFF->0); go to WAIT_LOW.
REQ-023 WAIT_LOW: stay until write_en=0, then IDLE; prevents a second burst from a still-high write_en.
REQ-024 Data pattern: wdata split into DW/32 words; word k (k=0 at LSB) = {addr_lat[23:0], beat[3:0], k[3:0]}; addr_lat zero-extended if CTRL_ADDR_WIDTH<24, truncated to [23:0] otherwise.
REQ-025 axi_wstrb SHALL be all ones whenever wvalid=1, zero otherwise.
REQ-026 Minimum burst latency from write_en sampled high to write_done_p with awready, wready tied high: 3+len cycles (ADDR 1, DATA len+1, DONE pulse).
REQ-027 awready asserted while not in ADDR, or wready while not in DATA, SHALL have no effect.
REQ-028 No W beat SHALL be issued before the AW handshake of the same burst completes.

Reset
REQ-029 rst=1 at a rising edge: state=IDLE, beat counter=0, latched addr/id/len=0, wr_burst_cnt=0 at the next cycle.
REQ-030 Reset values: axi_awvalid=0, axi_wvalid=0, axi_wlast=0, axi_wstrb=0, write_done_p=0, wr_busy=0, axi_awaddr=0, axi_awid=0, axi_awlen=0, axi_wdata=0.
REQ-031 Reset mid-burst SHALL abort silently: no write_done_p, counter not incremented.

Verification
REQ-032 awready=wready=1, addr=0x0000080, id=3, len=0, write_en pulsed high until done -> one AW (awaddr=0x80, awid=3, awlen=0), one W beat with wlast=1, word0=0x00008000, write_done_p 3 cycles after write_en sampled, wr_burst_cnt=1.
REQ-033 len=15, wready toggling 1/0 each cycle -> 16 beats, beat field 0..15 in order, wlast only on beat 15, data held stable during wready=0.
REQ-034 awready held low 10 cycles -> awvalid stays high with constant addr, no wvalid before AW handshake.
REQ-035 write_en held high 20 cycles after write_done_p -> exactly one burst; new burst only after write_en drops and rises again.
REQ-036 rst asserted during DATA at beat 5 of len=15 -> next cycle all outputs at reset values, no write_done_p, wr_burst_cnt unchanged at 0.
REQ-037 random_rw_addr changed every cycle during burst -> awaddr and wdata addr field reflect the value sampled in IDLE only.

Source files
------------

// File: rtl/test_wr_ctrl_if.sv
// test_wr_ctrl_if: AXI write address/data channels between the burst generator and the memory side.
interface test_wr_ctrl_if #(
   parameter int CTRL_ADDR_WIDTH = 28,
   parameter int MEM_DQ_WIDTH = 16
);
   localparam int DW = MEM_DQ_WIDTH * 8;
   logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr;
   logic [3:0] axi_awid;
   logic [3:0] axi_awlen;
   logic axi_awvalid;
   logic axi_awready;
   logic [DW-1:0] axi_wdata;
   logic [DW/8-1:0] axi_wstrb;
   logic axi_wlast;
   logic axi_wvalid;
   logic axi_wready;
   modport master (
      output axi_awaddr, axi_awid, axi_awlen, axi_awvalid,
      output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
      input axi_awready, axi_wready
   );
   modport slave (
      input axi_awaddr, axi_awid, axi_awlen, axi_awvalid,
      input axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
      output axi_awready, axi_wready
   );
endinterface

// File: rtl/test_wr_ctrl.sv
// test_wr_ctrl: issues one AXI write burst per write_en request, filling each beat with an address/beat/word pattern.
module test_wr_ctrl #(
   parameter int CTRL_ADDR_WIDTH = 28,
   parameter int MEM_DQ_WIDTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic write_en,
   input  logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
   input  logic [3:0] random_axi_id,
   input  logic [3:0] random_axi_len,
   output logic write_done_p,
   output logic wr_busy,
   output logic [31:0] wr_burst_cnt,
   test_wr_ctrl_if.master axi
);
   localparam int DW = MEM_DQ_WIDTH * 8;
   localparam int NW = DW / 32;
   typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, WAIT_LOW} state_t;
   state_t state_q, state_d;
   logic [CTRL_ADDR_WIDTH-1:0] addr_q;
   logic [3:0] id_q, len_q, beat_q;
   logic [31:0] cnt_q;
   logic [23:0] addr24;
   logic [DW-1:0] wdata;
   logic last, wv;

   assign last = beat_q == len_q;
   assign wv = state_q == DATA;
   assign addr24 = 24'(addr_q);
   assign wr_burst_cnt = cnt_q;

   for (genvar k = 0; k < NW; k++) begin : g_word
      assign wdata[32*k +: 32] = {addr24, beat_q, 4'(k)};
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = write_en ? ADDR : IDLE;
         ADDR:     state_d = axi.axi_awready ? DATA : ADDR;
         DATA:     state_d = (axi.axi_wready && last) ? DONE : DATA;
         DONE:     state_d = WAIT_LOW;
         WAIT_LOW: state_d = write_en ? WAIT_LOW : IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // request fields are captured only when leaving IDLE so the burst ignores later input changes
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         id_q <= '0;
         len_q <= '0;
         beat_q <= '0;
         cnt_q <= '0;
      end else begin
         if (state_q == IDLE && write_en) begin
            addr_q <= random_rw_addr;
            id_q <= random_axi_id;
            len_q <= random_axi_len;
            beat_q <= '0;
         end
         if (wv && axi.axi_wready) beat_q <= beat_q + 4'd1;
         if (state_q == DONE) cnt_q <= cnt_q + 32'd1;
      end
   end

   always_comb begin
      axi.axi_awvalid = state_q == ADDR;
      axi.axi_awaddr = addr_q;
      axi.axi_awid = id_q;
      axi.axi_awlen = len_q;
      axi.axi_wvalid = wv;
      axi.axi_wlast = wv && last;
      axi.axi_wstrb = wv ? '1 : '0;
      axi.axi_wdata = wv ? wdata : '0;
      write_done_p = state_q == DONE;
      wr_busy = state_q != IDLE;
   end
endmodule

// File: tb/tb_test_wr_ctrl.sv
// tb_test_wr_ctrl: table-driven cycle vectors plus directed and randomized bursts checked against a burst-level model.
module tb_test_wr_ctrl;
   localparam int AW = 28;
   localparam int DQ = 16;
   localparam int DW = DQ * 8;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic clk = 1'b0;
   logic rst, write_en, write_done_p, wr_busy;
   logic [AW-1:0] random_rw_addr;
   logic [3:0] random_axi_id, random_axi_len;
   logic [31:0] wr_burst_cnt;
   int tests = 0;
   int fails = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   test_wr_ctrl_if #(.CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ)) axi ();

   test_wr_ctrl #(.CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ)) dut (
      .clk(clk),
      .rst(rst),
      .write_en(write_en),
      .random_rw_addr(random_rw_addr),
      .random_axi_id(random_axi_id),
      .random_axi_len(random_axi_len),
      .write_done_p(write_done_p),
      .wr_busy(wr_busy),
      .wr_burst_cnt(wr_burst_cnt),
      .axi(axi.master)
   );

   typedef struct {
      logic r, we, ar, wr;
      logic busy, awv, wv, wl, dn;
      logic [31:0] cnt;
      logic [AW-1:0] awaddr;
      logic [31:0] w0;
   } vec_t;
   vec_t tv[14];

   task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input int b);
      logic [DW-1:0] r;
      for (int k = 0; k < DW / 32; k++) r[32*k +: 32] = {a[23:0], 4'(b), 4'(k)};
      return r;
   endfunction

   // drives one burst request and checks every cycle against the expected AW/W/done sequence
   task automatic burst(input logic [AW-1:0] a, input logic [3:0] id, input logic [3:0] len,
                        input int aw_stall, input int wmode, input bit chaos, input int hold, input int abort_at);
      int cyc, beat;
      bit aw_done, tog, fin;
      cyc = 0;
      beat = 0;
      aw_done = 0;
      tog = 1'b1;
      fin = 0;
      random_rw_addr = a;
      random_axi_id = id;
      random_axi_len = len;
      write_en = 1'b1;
      axi.axi_awready = 1'($urandom);
      axi.axi_wready = 1'($urandom);
      while (!fin && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (chaos) begin
            random_rw_addr = AW'($urandom);
            random_axi_id = 4'($urandom);
            random_axi_len = 4'($urandom);
         end
         if (!aw_done) begin
            chk("awvalid in addr", axi.axi_awvalid, 1);
            chk("wvalid before aw", axi.axi_wvalid, 0);
            chk("awaddr", axi.axi_awaddr, a);
            chk("awid", axi.axi_awid, id);
            chk("awlen", axi.axi_awlen, len);
            axi.axi_awready = cyc > aw_stall;
            axi.axi_wready = 1'($urandom);
            aw_done = axi.axi_awready;
         end else if (beat <= int'(len)) begin
            chk("awvalid in data", axi.axi_awvalid, 0);
            chk("wvalid", axi.axi_wvalid, 1);
            chk("wlast", axi.axi_wlast, beat == int'(len));
            chk("wdata", axi.axi_wdata, exp_data(a, beat));
            chk("wstrb", axi.axi_wstrb, {(DW/8){1'b1}});
            chk("done in data", write_done_p, 0);
            if (beat == abort_at) begin
               rst = 1'b1;
               write_en = 1'b0;
               @(negedge clk);
               rst = 1'b0;
               chk("abort busy", wr_busy, 0);
               chk("abort awvalid", axi.axi_awvalid, 0);
               chk("abort wvalid", axi.axi_wvalid, 0);
               chk("abort wlast", axi.axi_wlast, 0);
               chk("abort wstrb", axi.axi_wstrb, 0);
               chk("abort wdata", axi.axi_wdata, 0);
               chk("abort awaddr", axi.axi_awaddr, 0);
               chk("abort awid", axi.axi_awid, 0);
               chk("abort awlen", axi.axi_awlen, 0);
               chk("abort cnt", wr_burst_cnt, exp_cnt);
               for (int i = 0; i < 3; i++) begin
                  @(negedge clk);
                  chk("abort no done", write_done_p, 0);
                  chk("abort idle", wr_busy, 0);
               end
               return;
            end
            axi.axi_awready = 1'($urandom);
            if (wmode == 0) axi.axi_wready = 1'b1;
            else if (wmode == 1) begin
               axi.axi_wready = tog;
               tog = ~tog;
            end else axi.axi_wready = 1'($urandom);
            if (axi.axi_wready) beat++;
         end else begin
            chk("done pulse", write_done_p, 1);
            chk("busy in done", wr_busy, 1);
            chk("wvalid in done", axi.axi_wvalid, 0);
            if (aw_stall == 0 && wmode == 0) chk("latency", cyc, 3 + int'(len));
            fin = 1;
         end
      end
      if (!fin) begin
         tests++;
         fails++;
         $display("FAIL burst timeout: got no write_done_p required within 300 cycles");
         write_en = 1'b0;
         return;
      end
      exp_cnt++;
      write_en = hold > 0;
      @(negedge clk);
      chk("done one cycle", write_done_p, 0);
      chk("busy after done", wr_busy, 1);
      chk("burst count", wr_burst_cnt, exp_cnt);
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         chk("held en no awvalid", axi.axi_awvalid, 0);
         chk("held en busy", wr_busy, 1);
         chk("held en no done", write_done_p, 0);
      end
      write_en = 1'b0;
      @(negedge clk);
      chk("back to idle", wr_busy, 0);
      chk("count stable", wr_burst_cnt, exp_cnt);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //           r  we ar wr  busy awv wv wl dn  cnt  awaddr   w0
      tv[0]  = '{H, L, L, L,  L, L, L, L, L,  0, 28'h0,  32'h0};
      tv[1]  = '{L, H, H, H,  H, H, L, L, L,  0, 28'h80, 32'h0};
      tv[2]  = '{L, H, H, H,  H, L, H, H, L,  0, 28'h80, 32'h00008000};
      tv[3]  = '{L, H, H, H,  H, L, L, L, H,  0, 28'h80, 32'h0};
      tv[4]  = '{L, H, H, H,  H, L, L, L, L,  1, 28'h80, 32'h0};
      tv[5]  = '{L, H, H, H,  H, L, L, L, L,  1, 28'h80, 32'h0};
      tv[6]  = '{L, L, H, H,  L, L, L, L, L,  1, 28'h80, 32'h0};
      tv[7]  = '{L, L, H, H,  L, L, L, L, L,  1, 28'h80, 32'h0};
      tv[8]  = '{L, H, L, H,  H, H, L, L, L,  1, 28'h80, 32'h0};
      tv[9]  = '{L, H, L, H,  H, H, L, L, L,  1, 28'h80, 32'h0};
      tv[10] = '{L, H, H, L,  H, L, H, H, L,  1, 28'h80, 32'h00008000};
      tv[11] = '{L, H, H, L,  H, L, H, H, L,  1, 28'h80, 32'h00008000};
      tv[12] = '{H, H, H, H,  L, L, L, L, L,  0, 28'h0,  32'h0};
      tv[13] = '{L, L, H, H,  L, L, L, L, L,  0, 28'h0,  32'h0};
      random_rw_addr = 28'h80;
      random_axi_id = 4'd3;
      random_axi_len = 4'd0;
      for (int i = 0; i < 14; i++) begin
         rst = tv[i].r;
         write_en = tv[i].we;
         axi.axi_awready = tv[i].ar;
         axi.axi_wready = tv[i].wr;
         @(negedge clk);
         chk($sformatf("vec%0d busy", i), wr_busy, tv[i].busy);
         chk($sformatf("vec%0d awvalid", i), axi.axi_awvalid, tv[i].awv);
         chk($sformatf("vec%0d wvalid", i), axi.axi_wvalid, tv[i].wv);
         chk($sformatf("vec%0d wlast", i), axi.axi_wlast, tv[i].wl);
         chk($sformatf("vec%0d done", i), write_done_p, tv[i].dn);
         chk($sformatf("vec%0d cnt", i), wr_burst_cnt, tv[i].cnt);
         chk($sformatf("vec%0d awaddr", i), axi.axi_awaddr, tv[i].awaddr);
         chk($sformatf("vec%0d awid", i), axi.axi_awid, tv[i].awaddr != 0 ? 4'd3 : 4'd0);
         chk($sformatf("vec%0d word0", i), axi.axi_wdata[31:0], tv[i].w0);
         chk($sformatf("vec%0d wstrb", i), axi.axi_wstrb, tv[i].wv ? {(DW/8){1'b1}} : '0);
      end
      rst = 1'b0;
      write_en = 1'b0;
      @(negedge clk);
      exp_cnt = 0;
      burst(28'h0123456, 4'd2, 4'd15, 0, 0, 0, 0, 5);
      burst(28'h0000080, 4'd3, 4'd0, 0, 0, 0, 0, -1);
      burst(28'h1234567, 4'd5, 4'd15, 0, 1, 0, 0, -1);
      burst(28'hABCDEF0, 4'd7, 4'd3, 10, 0, 0, 0, -1);
      burst(28'h0000055, 4'd1, 4'd2, 0, 0, 0, 20, -1);
      burst(28'h0FEDCBA, 4'd9, 4'd7, 2, 2, 1, 1, -1);
      for (int i = 0; i < 40; i++)
         burst(AW'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 2,
               1'($urandom), int'($urandom_range(0, 2)), -1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
